multiplexer_4to1: RTL and testbench



---
 rtl/multiplexer_4to1.sv | 71 +++++++
 tb/tb_multiplexer_4to1.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexer_4to1.sv
// Registered 4:1 single-bit multiplexer with a one-hot copy of the captured select.
// The selected bit I[S] appears on Y one clock after it is sampled. SEL_OH carries
// 4'b0001 << S and is all-zero only between reset and the first enabled capture.
// Define MULTIPLEXER_BYPASS_EN to build a purely combinational variant: zero latency,
// en ignored, and clk/rst_n kept only for port compatibility.
module multiplexer_4to1 #(
  parameter logic RESET_Y = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] S,
  input  logic [3:0] I,
  output logic       Y,
  output logic [3:0] SEL_OH
);

  logic       y_d;
  logic [3:0] sel_oh_d;

  // Decode the select into the chosen data bit and its one-hot form; all four codes are legal
  always_comb begin
    y_d      = 1'b0;
    sel_oh_d = 4'b0000;
    unique case (S)
      2'b00: begin
        y_d      = I[0];
        sel_oh_d = 4'b0001;
      end
      2'b01: begin
        y_d      = I[1];
        sel_oh_d = 4'b0010;
      end
      2'b10: begin
        y_d      = I[2];
        sel_oh_d = 4'b0100;
      end
      2'b11: begin
        y_d      = I[3];
        sel_oh_d = 4'b1000;
      end
    endcase
  end

`ifdef MULTIPLEXER_BYPASS_EN
  // Control inputs and the reset value are unused in the combinational build
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst_n, en, RESET_Y};

  assign Y      = y_d;
  assign SEL_OH = sel_oh_d;
`else
  logic       y_q;
  logic [3:0] sel_oh_q;

  // Output registers: asynchronous clear, capture only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= RESET_Y;
      sel_oh_q <= 4'b0000;
    end else if (en) begin
      y_q      <= y_d;
      sel_oh_q <= sel_oh_d;
    end
  end

  assign Y      = y_q;
  assign SEL_OH = sel_oh_q;
`endif

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Self-checking bench for multiplexer_4to1: directed scenarios plus randomized
// traffic checked against a behavioural model (Y = bit S of I, one-hot = 1 << S).
module tb_multiplexer_4to1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] S;
  logic [3:0] I;
  logic       Y;
  logic [3:0] SEL_OH;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic       exp_y;
  logic [3:0] exp_oh;

  multiplexer_4to1 #(
    .RESET_Y(1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .S     (S),
    .I     (I),
    .Y     (Y),
    .SEL_OH(SEL_OH)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model update for one rising edge, using the inputs present at that edge
  task automatic model_edge();
    if (rst_n && en) begin
      exp_y  = ((int'(I) >> int'(S)) % 2) == 1;
      exp_oh = 4'(1 << int'(S));
    end
  endtask

  task automatic model_reset();
    exp_y  = 1'b0;
    exp_oh = 4'b0000;
  endtask

`ifndef MULTIPLEXER_BYPASS_EN
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    I     = 4'b1111;
    S     = 2'b11;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (Y !== exp_y || SEL_OH !== exp_oh) begin
        n_err++;
        $display("FAIL reset: got Y=%b SEL_OH=%b, want Y=%b SEL_OH=%b", Y, SEL_OH, exp_y, exp_oh);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic       want_y  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] want_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en = 1'b1;
      I  = 4'b0101;
      S  = 2'(k);
      @(posedge clk);
      model_edge();
      #1;
      n_cmp++;
      if (Y !== want_y[k] || SEL_OH !== want_oh[k]) begin
        n_err++;
        $display("FAIL sweep S=%0d: got Y=%b SEL_OH=%b, want Y=%b SEL_OH=%b",
                 k, Y, SEL_OH, want_y[k], want_oh[k]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    en = 1'b1;
    I  = 4'b0101;
    S  = 2'b00;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    en = 1'b0;
    S  = 2'b01;
    I  = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      n_cmp++;
      if (Y !== 1'b1 || SEL_OH !== 4'b0001) begin
        n_err++;
        $display("FAIL hold edge %0d: got Y=%b SEL_OH=%b, want Y=1 SEL_OH=0001", k, Y, SEL_OH);
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    en = 1'b1;
    S  = 2'b10;
    I  = 4'b0100;
    @(posedge clk);
    model_edge();
    #2;
    for (int k = 0; k < 3; k++) begin
      I[2] = ~I[2];
      #1;
      n_cmp++;
      if (Y !== 1'b1) begin
        n_err++;
        $display("FAIL glitch toggle %0d: got Y=%b, want Y=1", k, Y);
      end
    end
    I[2] = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    n_cmp++;
    if (Y !== 1'b0 || SEL_OH !== 4'b0100) begin
      n_err++;
      $display("FAIL glitch edge: got Y=%b SEL_OH=%b, want Y=0 SEL_OH=0100", Y, SEL_OH);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    en = 1'b1;
    S  = 2'b00;
    I  = 4'b0001;
    @(posedge clk);
    model_edge();
    #1;
    n_cmp++;
    if (Y !== 1'b1) begin
      n_err++;
      $display("FAIL async pre: got Y=%b, want Y=1", Y);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (Y !== 1'b0 || SEL_OH !== 4'b0000) begin
      n_err++;
      $display("FAIL async assert: got Y=%b SEL_OH=%b, want Y=0 SEL_OH=0000", Y, SEL_OH);
    end
    #1;
    rst_n = 1'b1;
    S     = 2'b11;
    I     = 4'b1000;
    @(posedge clk);
    model_edge();
    #1;
    n_cmp++;
    if (Y !== 1'b1 || SEL_OH !== 4'b1000) begin
      n_err++;
      $display("FAIL async recover: got Y=%b SEL_OH=%b, want Y=1 SEL_OH=1000", Y, SEL_OH);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      S  = 2'($urandom_range(0, 3));
      I  = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_edge();
      #1;
      n_cmp++;
      if (Y !== exp_y || SEL_OH !== exp_oh) begin
        n_err++;
        $display("FAIL random %0d: got Y=%b SEL_OH=%b, want Y=%b SEL_OH=%b",
                 k, Y, SEL_OH, exp_y, exp_oh);
      end
    end
  endtask
`else
  task automatic test_bypass();
    rst_n = 1'b0;
    en    = 1'b0;
    for (int r = 0; r < 40; r++) begin
      I = (r < 4) ? 4'b0101 : 4'($urandom_range(0, 15));
      S = (r < 4) ? 2'(r) : 2'($urandom_range(0, 3));
      #1;
      n_cmp++;
      if (Y !== (((int'(I) >> int'(S)) % 2) == 1) || SEL_OH !== 4'(1 << int'(S))) begin
        n_err++;
        $display("FAIL bypass I=%b S=%0d: got Y=%b SEL_OH=%b", I, S, Y, SEL_OH);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    S     = 2'b00;
    I     = 4'b0000;
    model_reset();
`ifndef MULTIPLEXER_BYPASS_EN
    test_reset();
    test_sweep();
    test_hold();
    test_glitch();
    test_async_reset();
    test_random();
`else
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
